// File: rtl/mips_exec_ctrl.sv
// Single-cycle MIPS decode/execute slice: main and ALU control decoders, the
// source-B mux, a 32-bit ALU and a small registered status stage for debug/trap.
module mips_exec_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [WIDTH-1:0] SignImm,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             Branch,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             Jump,
  output logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             PCSrc,
  output logic [WIDTH-1:0] aluResult_q,
  output logic             zero_q,
  output logic             illegal
);

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  alu_op_t    alu_op;
  logic       reg_write_main;
  logic       illegal_op;
  logic       illegal_funct;
  logic       illegal_event;

  always_comb begin
    reg_write_main = 1'b0;
    RegDst         = 1'b0;
    ALUSrc         = 1'b0;
    Branch         = 1'b0;
    MemWrite       = 1'b0;
    MemtoReg       = 1'b0;
    Jump           = 1'b0;
    alu_op         = ALUOP_ADD;
    illegal_op     = 1'b0;
    unique case (op)
      6'b000000: begin
        reg_write_main = 1'b1;
        RegDst         = 1'b1;
        alu_op         = ALUOP_FUNCT;
      end
      6'b100011: begin
        reg_write_main = 1'b1;
        ALUSrc         = 1'b1;
        MemtoReg       = 1'b1;
      end
      6'b101011: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      6'b000100: begin
        Branch = 1'b1;
        alu_op = ALUOP_SUB;
      end
      6'b001000: begin
        reg_write_main = 1'b1;
        ALUSrc         = 1'b1;
      end
      6'b000010: Jump = 1'b1;
      default:   illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    ALUControl    = 3'b010;
    illegal_funct = 1'b0;
    case (alu_op)
      ALUOP_SUB: ALUControl = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default: begin
            ALUControl    = 3'b011;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // An unknown R-type funct must not write back its (zero) result.
  assign RegWrite      = reg_write_main & ~illegal_funct;
  assign illegal_event = illegal_op | illegal_funct;

  assign SrcB = ALUSrc ? SignImm : RD2;

  always_comb begin
    aluResult = '0;
    unique case (ALUControl)
      3'b000: aluResult = RD1 & SrcB;
      3'b001: aluResult = RD1 | SrcB;
      3'b010: aluResult = RD1 + SrcB;
      3'b110: aluResult = RD1 - SrcB;
      // True signed compare, so the result stays correct when A - B overflows.
      3'b111: aluResult = {{(WIDTH-1){1'b0}}, ($signed(RD1) < $signed(SrcB))};
      3'b100: aluResult = RD1 & ~SrcB;
      3'b101: aluResult = RD1 | ~SrcB;
      default: aluResult = '0;
    endcase
  end

  assign zero  = (aluResult == '0);
  assign PCSrc = Branch & zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aluResult_q <= '0;
      zero_q      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      aluResult_q <= aluResult;
      zero_q      <= zero;
      illegal     <= illegal | illegal_event;
    end
  end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Randomized self-checking bench for mips_exec_ctrl against a table-driven
// behavioural model of the decoder, ALU and status registers.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic [31:0] RD1, RD2, SignImm;
  logic        MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump;
  logic [2:0]  ALUControl;
  logic [31:0] SrcB, aluResult, aluResult_q;
  logic        zero, PCSrc, zero_q, illegal;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] e_q;
  logic        e_zq, e_ill;

  mips_exec_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .RD1(RD1), .RD2(RD2), .SignImm(SignImm),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .RegWrite(RegWrite), .Jump(Jump), .ALUControl(ALUControl),
    .SrcB(SrcB), .aluResult(aluResult), .zero(zero), .PCSrc(PCSrc),
    .aluResult_q(aluResult_q), .zero_q(zero_q), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control word order: RegWrite RegDst ALUSrc Branch MemWrite MemtoReg Jump.
  function automatic void model(input logic [5:0] o, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] rd2,
                                input logic [31:0] imm,
                                output logic [6:0] ctl, output logic [2:0] ac,
                                output logic [31:0] sb, output logic [31:0] res,
                                output logic ev);
    logic [1:0] aop;
    ev = 1'b0;
    case (o)
      6'o00:   begin ctl = 7'b1100000; aop = 2'b10; end
      6'o43:   begin ctl = 7'b1010010; aop = 2'b00; end
      6'o53:   begin ctl = 7'b0010100; aop = 2'b00; end
      6'o04:   begin ctl = 7'b0001000; aop = 2'b01; end
      6'o10:   begin ctl = 7'b1010000; aop = 2'b00; end
      6'o02:   begin ctl = 7'b0000001; aop = 2'b00; end
      default: begin ctl = 7'b0000000; aop = 2'b00; ev = 1'b1; end
    endcase
    if (aop == 2'b00)      ac = 3'b010;
    else if (aop == 2'b01) ac = 3'b110;
    else begin
      case (f)
        6'h20: ac = 3'b010;
        6'h22: ac = 3'b110;
        6'h24: ac = 3'b000;
        6'h25: ac = 3'b001;
        6'h2a: ac = 3'b111;
        default: begin ac = 3'b011; ctl[6] = 1'b0; ev = 1'b1; end
      endcase
    end
    sb = ctl[4] ? imm : rd2;
    case (ac)
      3'b000: res = a & sb;
      3'b001: res = a | sb;
      3'b010: res = 32'((64'(a) + 64'(sb)) % 64'h1_0000_0000);
      3'b110: res = 32'((64'(a) + 64'h1_0000_0000 - 64'(sb)) % 64'h1_0000_0000);
      3'b111: res = (int'(a) < int'(sb)) ? 32'd1 : 32'd0;
      3'b100: res = a & ~sb;
      3'b101: res = a | ~sb;
      default: res = 32'd0;
    endcase
  endfunction

  task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic r);
    logic [6:0]  e_ctl;
    logic [2:0]  e_ac;
    logic [31:0] e_sb, e_res;
    logic        e_ev;
    @(negedge clk);
    op = o; funct = f; RD1 = a; RD2 = b; SignImm = imm; rst_n = r;
    model(o, f, a, b, imm, e_ctl, e_ac, e_sb, e_res, e_ev);
    #1;
    check("ctl", 64'({RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump}), 64'(e_ctl));
    check("ALUControl", 64'(ALUControl), 64'(e_ac));
    check("SrcB", 64'(SrcB), 64'(e_sb));
    check("aluResult", 64'(aluResult), 64'(e_res));
    check("zero", 64'(zero), 64'(e_res == 32'd0));
    check("PCSrc", 64'(PCSrc), 64'(e_ctl[3] && e_res == 32'd0));
    e_q   = r ? e_res : 32'd0;
    e_zq  = r ? (e_res == 32'd0) : 1'b0;
    e_ill = r ? (e_ill | e_ev) : 1'b0;
    @(posedge clk);
    #1;
    check("aluResult_q", 64'(aluResult_q), 64'(e_q));
    check("zero_q", 64'(zero_q), 64'(e_zq));
    check("illegal", 64'(illegal), 64'(e_ill));
  endtask

  logic [5:0] ops [0:5] = '{6'o00, 6'o43, 6'o53, 6'o04, 6'o10, 6'o02};
  logic [5:0] fns [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 4))
      0:       return $urandom_range(0, 15);
      1:       return 32'h8000_0000 + $urandom_range(0, 3);
      2:       return 32'h7fff_ffff - $urandom_range(0, 3);
      3:       return 32'hffff_ffff - $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; RD1 = '0; RD2 = '0; SignImm = '0;
    e_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_aluResult_q", 64'(aluResult_q), 64'd0);
    check("rst_zero_q", 64'(zero_q), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);

    apply(6'o00, 6'h20, 32'd5, 32'd7, 32'd0, 1'b1);
    check("add_result", 64'(aluResult), 64'd12);
    check("add_q", 64'(aluResult_q), 64'd12);
    apply(6'o43, 6'h00, 32'h100, 32'h0, 32'hffff_fffc, 1'b1);
    check("lw_result", 64'(aluResult), 64'h0fc);
    apply(6'o53, 6'h00, 32'h100, 32'h0, 32'hffff_fffc, 1'b1);
    check("sw_memwrite", 64'({MemWrite, RegWrite}), 64'b10);
    apply(6'o04, 6'h00, 32'd9, 32'd9, 32'd0, 1'b1);
    check("beq_taken", 64'(PCSrc), 64'd1);
    apply(6'o04, 6'h00, 32'd9, 32'd8, 32'd0, 1'b1);
    check("beq_not_taken", 64'(PCSrc), 64'd0);
    apply(6'o00, 6'h2a, 32'h8000_0000, 32'd1, 32'd0, 1'b1);
    check("slt_neg", 64'(aluResult), 64'd1);
    apply(6'o00, 6'h2a, 32'd1, 32'h8000_0000, 32'd0, 1'b1);
    check("slt_swap", 64'(aluResult), 64'd0);
    apply(6'o00, 6'h24, 32'hf0f0, 32'h0ff0, 32'd0, 1'b1);
    check("and", 64'(aluResult), 64'h00f0);
    apply(6'o00, 6'h25, 32'hf0f0, 32'h0ff0, 32'd0, 1'b1);
    check("or", 64'(aluResult), 64'hfff0);
    apply(6'o77, 6'h20, 32'd3, 32'd4, 32'd0, 1'b1);
    check("illegal_set", 64'(illegal), 64'd1);
    apply(6'o00, 6'h20, 32'd1, 32'd1, 32'd0, 1'b1);
    check("illegal_sticky", 64'(illegal), 64'd1);
    apply(6'o77, 6'h3f, 32'd1, 32'd1, 32'd0, 1'b0);
    check("reset_clears", 64'({illegal, zero_q, aluResult_q}), 64'd0);
    apply(6'o00, 6'h3f, 32'd1, 32'd2, 32'd0, 1'b1);
    check("bad_funct_regwrite", 64'({RegWrite, illegal}), 64'b01);

    for (int i = 0; i < 400; i++) begin
      logic [5:0]  o, f;
      logic [31:0] a, b;
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      a = rand_data();
      b = ($urandom_range(0, 5) == 0) ? a : rand_data();
      apply(o, f, a, b, rand_data(), ($urandom_range(0, 19) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
